// File: rtl/clk_meter_pkg.sv
// +----------------------------------------------------------------------------+
// | clk_meter_pkg : shared states and default constants for clk_period_meter     |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

package clk_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2,
    ST_DONE = 2'd3
  } meter_state_e;

  localparam int          DEF_CNT_W       = 32;
  localparam int unsigned DEF_TIMEOUT     = 200_000_000;
  localparam int          DEF_SYNC_STAGES = 2;

endpackage

`default_nettype wire

// File: rtl/clk_period_meter_if.sv
// +----------------------------------------------------------------------------+
// | clk_period_meter_if : request / result bus of the period meter              |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

interface clk_period_meter_if
  import clk_meter_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) ();

  logic             start;
  logic             busy;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             timeout;

  modport master (
    output start,
    input  busy, period, high_time, valid, timeout
  );

  modport slave (
    input  start,
    output busy, period, high_time, valid, timeout
  );

endinterface

`default_nettype wire

// File: rtl/sync_edge_det.sv
// +----------------------------------------------------------------------------+
// | sync_edge_det : multi-flop synchronizer with rise / fall strobes            |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module sync_edge_det
  import clk_meter_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  wire logic clk_100M,
  input  wire logic rst_n,
  input  wire logic d,
  output logic      level,
  output logic      rise,
  output logic      fall
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  logic              prev_q;
  logic              prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // Strobes come from the last synchronizer stage and the edge-detect flop,
  // so both edges carry the same latency.
  assign level = sync_q[STAGES-1];
  assign rise  = sync_q[STAGES-1] & ~prev_q;
  assign fall  = ~sync_q[STAGES-1] & prev_q;

endmodule

`default_nettype wire

// File: rtl/clk_period_meter.sv
// +----------------------------------------------------------------------------+
// | clk_period_meter : measures period and high time of a slow async signal     |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int          CNT_W       = DEF_CNT_W,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
  parameter int          SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  wire logic          clk_100M,
  input  wire logic          rst_n,
  input  wire logic          sig_in,
  clk_period_meter_if.slave  bus
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic sig_level;
  logic sig_rise;
  logic sig_fall;

  sync_edge_det #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_100M (clk_100M),
    .rst_n    (rst_n),
    .d        (sig_in),
    .level    (sig_level),
    .rise     (sig_rise),
    .fall     (sig_fall)
  );

  meter_state_e     state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [CNT_W-1:0] hcnt_q,      hcnt_d;
  logic [CNT_W-1:0] wcnt_q,      wcnt_d;
  logic [CNT_W-1:0] period_q,    period_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic             busy_q,      busy_d;
  logic             valid_q,     valid_d;
  logic             timeout_q,   timeout_d;

  logic [CNT_W-1:0] wcnt_inc;
  logic             wait_expired;

  always_comb begin
    wcnt_inc     = sat_inc(wcnt_q);
    wait_expired = (wcnt_inc >= TIMEOUT_CNT);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hcnt_d      = hcnt_q;
    wcnt_d      = wcnt_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    timeout_d   = timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d   = ST_ARM;
          timeout_d = 1'b0;
          wcnt_d    = '0;
        end
      end

      ST_ARM: begin
        if (sig_rise) begin
          state_d = ST_MEAS;
          cnt_d   = CNT_W'(1);
          hcnt_d  = CNT_W'(1);
          wcnt_d  = '0;
        end else if (wait_expired) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end else begin
          wcnt_d = wcnt_inc;
        end
      end

      ST_MEAS: begin
        // A rise always closes the measurement, even on the expiry cycle.
        if (sig_rise) begin
          state_d     = ST_DONE;
          period_d    = cnt_q;
          high_time_d = hcnt_q;
        end else if (sig_fall) begin
          cnt_d  = sat_inc(cnt_q);
          wcnt_d = '0;
        end else if (wait_expired) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end else begin
          cnt_d  = sat_inc(cnt_q);
          hcnt_d = sig_level ? sat_inc(hcnt_q) : hcnt_q;
          wcnt_d = wcnt_inc;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d  = (state_d != ST_IDLE);
    valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hcnt_q      <= '0;
      wcnt_q      <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hcnt_q      <= hcnt_d;
      wcnt_q      <= wcnt_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.valid     = valid_q;
  assign bus.timeout   = timeout_q;
  assign bus.period    = period_q;
  assign bus.high_time = high_time_q;

endmodule

`default_nettype wire

// File: tb/tb_clk_period_meter.sv
// +----------------------------------------------------------------------------+
// | tb_clk_period_meter : self-checking bench for clk_period_meter              |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_clk_period_meter;

  logic clk;
  logic rst_n;
  logic sig_a;
  logic sig_t;

  clk_period_meter_if #(.CNT_W(32)) bus_a ();
  clk_period_meter_if #(.CNT_W(32)) bus_t ();

  clk_period_meter #(
    .CNT_W       (32),
    .TIMEOUT     (4000),
    .SYNC_STAGES (2)
  ) dut_a (
    .clk_100M (clk),
    .rst_n    (rst_n),
    .sig_in   (sig_a),
    .bus      (bus_a.slave)
  );

  clk_period_meter #(
    .CNT_W       (32),
    .TIMEOUT     (500),
    .SYNC_STAGES (2)
  ) dut_t (
    .clk_100M (clk),
    .rst_n    (rst_n),
    .sig_in   (sig_t),
    .bus      (bus_t.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // waveform generator configuration (written by main test only)
  int cyc = 0;
  int hi_a = 10, lo_a = 10, base_a = 0;
  int hi_t = 10, lo_t = 10, base_t = 0;
  bit gen_a = 1'b0, gen_t = 1'b0;
  bit lvl_a = 1'b0, lvl_t = 1'b0;

  initial begin
    sig_a = 1'b0;
    sig_t = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      sig_a = gen_a ? (((cyc - base_a) % (hi_a + lo_a)) < hi_a) : lvl_a;
      sig_t = gen_t ? (((cyc - base_t) % (hi_t + lo_t)) < hi_t) : lvl_t;
    end
  end

  int nval_a = 0;
  int nval_t = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (bus_a.valid) nval_a++;
      if (bus_t.valid) nval_t++;
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", name, got, exp);
    end
  endtask

  // Reference model: a square wave with hi high cycles and lo low cycles
  // measured rise-to-rise gives period hi+lo and high time hi.
  function automatic longint ref_period(input int hi, input int lo);
    return longint'(hi) + longint'(lo);
  endfunction
  function automatic longint ref_high(input int hi, input int lo);
    return (lo > 0) ? longint'(hi) : 0;
  endfunction

  function automatic logic r_busy(input bit t);
    return t ? bus_t.busy : bus_a.busy;
  endfunction
  function automatic logic r_valid(input bit t);
    return t ? bus_t.valid : bus_a.valid;
  endfunction
  function automatic logic r_tmo(input bit t);
    return t ? bus_t.timeout : bus_a.timeout;
  endfunction
  function automatic logic [31:0] r_period(input bit t);
    return t ? bus_t.period : bus_a.period;
  endfunction
  function automatic logic [31:0] r_high(input bit t);
    return t ? bus_t.high_time : bus_a.high_time;
  endfunction

  task automatic drive_start(input bit t, input logic v);
    if (t) bus_t.start = v;
    else   bus_a.start = v;
  endtask

  // Returns just after the accepting edge.
  task automatic pulse_start(input bit t);
    @(posedge clk);
    #1 drive_start(t, 1'b1);
    @(posedge clk);
    #1 drive_start(t, 1'b0);
  endtask

  task automatic set_gen(input bit t, input int hi, input int lo);
    @(negedge clk);
    if (t) begin hi_t = hi; lo_t = lo; base_t = cyc + 1; gen_t = 1'b1; end
    else   begin hi_a = hi; lo_a = lo; base_a = cyc + 1; gen_a = 1'b1; end
  endtask

  task automatic set_lvl(input bit t, input bit v);
    @(negedge clk);
    if (t) begin gen_t = 1'b0; lvl_t = v; end
    else   begin gen_a = 1'b0; lvl_a = v; end
  endtask

  task automatic measure(input bit t, input string tag, input longint exp_p, input longint exp_h);
    int          budget;
    bit          seen;
    bit          b1;
    bit          drop_ok;
    logic [31:0] p;
    logic [31:0] h;
    budget  = 3 * int'(exp_p) + 60;
    seen    = 1'b0;
    drop_ok = 1'b0;
    p = '0;
    h = '0;
    pulse_start(t);
    @(negedge clk);
    b1 = r_busy(t);
    for (int i = 0; i < budget && !seen; i++) begin
      if (r_valid(t)) begin
        seen = 1'b1;
        p = r_period(t);
        h = r_high(t);
        b1 = b1 & r_busy(t);
        @(negedge clk);
        drop_ok = !r_busy(t) && !r_valid(t);
      end else begin
        @(negedge clk);
      end
    end
    chk({tag, ".busy"},      longint'(b1), 1);
    chk({tag, ".valid"},     longint'(seen), 1);
    chk({tag, ".period"},    longint'(p), exp_p);
    chk({tag, ".high_time"}, longint'(h), exp_h);
    chk({tag, ".busy_drop"}, longint'(drop_ok), 1);
  endtask

  typedef struct {
    int hi;
    int lo;
    int exp_p;
    int exp_h;
    bit reconf;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int v0;
    int idx;
    bit ok;
    bit seen;
    logic [31:0] p;
    logic [31:0] h;

    vecs[0] = '{hi: 50,   lo: 50,  exp_p: 100,  exp_h: 50,   reconf: 1'b1};
    vecs[1] = '{hi: 300,  lo: 700, exp_p: 1000, exp_h: 300,  reconf: 1'b1};
    vecs[2] = '{hi: 300,  lo: 700, exp_p: 1000, exp_h: 300,  reconf: 1'b0};
    vecs[3] = '{hi: 2,    lo: 2,   exp_p: 4,    exp_h: 2,    reconf: 1'b1};
    vecs[4] = '{hi: 2,    lo: 9,   exp_p: 11,   exp_h: 2,    reconf: 1'b1};
    vecs[5] = '{hi: 9,    lo: 2,   exp_p: 11,   exp_h: 9,    reconf: 1'b1};
    vecs[6] = '{hi: 1200, lo: 800, exp_p: 2000, exp_h: 1200, reconf: 1'b1};

    rst_n = 1'b0;
    bus_a.start = 1'b0;
    bus_t.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst.busy",      longint'(bus_a.busy), 0);
    chk("rst.valid",     longint'(bus_a.valid), 0);
    chk("rst.timeout",   longint'(bus_a.timeout), 0);
    chk("rst.period",    longint'(bus_a.period), 0);
    chk("rst.high_time", longint'(bus_a.high_time), 0);
    chk("rst.t_busy",    longint'(bus_t.busy), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // table-driven measurements
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].reconf) begin
        set_gen(1'b0, vecs[i].hi, vecs[i].lo);
        repeat (8) @(negedge clk);
      end
      measure(1'b0, $sformatf("vec%0d", i), vecs[i].exp_p, vecs[i].exp_h);
    end

    // randomized waveforms against the reference model
    for (int i = 0; i < 8; i++) begin
      int hi;
      int lo;
      hi = int'($urandom_range(2, 300));
      lo = int'($urandom_range(2, 300));
      set_gen(1'b0, hi, lo);
      repeat (int'($urandom_range(5, 60))) @(negedge clk);
      measure(1'b0, $sformatf("rnd%0d_%0d_%0d", i, hi, lo), ref_period(hi, lo), ref_high(hi, lo));
    end

    // timeout while waiting for the first rise
    set_gen(1'b1, 20, 30);
    repeat (8) @(negedge clk);
    measure(1'b1, "t_pre", 50, 20);
    set_lvl(1'b1, 1'b0);
    repeat (10) @(negedge clk);
    v0 = nval_t;
    pulse_start(1'b1);
    ok = 1'b1;
    for (int k = 1; k <= 500; k++) begin
      @(negedge clk);
      ok = ok && bus_t.busy && !bus_t.timeout;
    end
    chk("arm_tmo.wait_busy", longint'(ok), 1);
    @(negedge clk);
    chk("arm_tmo.busy",      longint'(bus_t.busy), 0);
    chk("arm_tmo.timeout",   longint'(bus_t.timeout), 1);
    chk("arm_tmo.no_valid",  longint'(nval_t - v0), 0);
    chk("arm_tmo.period",    longint'(bus_t.period), 50);
    chk("arm_tmo.high_time", longint'(bus_t.high_time), 20);
    pulse_start(1'b1);
    @(negedge clk);
    chk("restart.timeout_clr", longint'(bus_t.timeout), 0);
    chk("restart.busy",        longint'(bus_t.busy), 1);
    repeat (510) @(negedge clk);
    chk("restart.timeout_again", longint'(bus_t.timeout), 1);

    // stuck high after the first rise
    v0 = nval_t;
    pulse_start(1'b1);
    repeat (20) @(negedge clk);
    set_lvl(1'b1, 1'b1);
    idx = 0;
    for (int k = 1; k <= 700 && idx == 0; k++) begin
      @(negedge clk);
      if (!bus_t.busy) idx = k;
    end
    chk("meas_tmo.when", longint'((idx >= 502 && idx <= 506) ? idx : -idx), longint'(idx));
    chk("meas_tmo.timeout",  longint'(bus_t.timeout), 1);
    chk("meas_tmo.no_valid", longint'(nval_t - v0), 0);
    chk("meas_tmo.period",   longint'(bus_t.period), 50);

    // extra starts while busy and on the valid cycle are ignored
    set_gen(1'b0, 50, 50);
    repeat (10) @(negedge clk);
    v0 = nval_a;
    pulse_start(1'b0);
    seen = 1'b0;
    p = '0;
    h = '0;
    for (int k = 0; k < 600 && !seen; k++) begin
      @(negedge clk);
      if (bus_a.valid) begin
        seen = 1'b1;
        p = bus_a.period;
        h = bus_a.high_time;
        drive_start(1'b0, 1'b1);
        @(negedge clk);
        drive_start(1'b0, 1'b0);
      end else begin
        drive_start(1'b0, (k % 13) == 6);
      end
    end
    drive_start(1'b0, 1'b0);
    repeat (400) @(negedge clk);
    chk("ignore.period",    longint'(p), 100);
    chk("ignore.high_time", longint'(h), 50);
    chk("ignore.one_valid", longint'(nval_a - v0), 1);
    chk("ignore.idle",      longint'(bus_a.busy), 0);

    // asynchronous reset in the middle of a measurement
    set_lvl(1'b0, 1'b0);
    repeat (10) @(negedge clk);
    pulse_start(1'b0);
    repeat (5) @(negedge clk);
    set_gen(1'b0, 100, 100);
    repeat (120) @(negedge clk);
    v0 = nval_a;
    chk("mid.busy_before", longint'(bus_a.busy), 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst.busy",      longint'(bus_a.busy), 0);
    chk("async_rst.period",    longint'(bus_a.period), 0);
    chk("async_rst.high_time", longint'(bus_a.high_time), 0);
    chk("async_rst.valid",     longint'(bus_a.valid), 0);
    chk("async_rst.timeout",   longint'(bus_t.timeout), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    chk("async_rst.no_valid", longint'(nval_a - v0), 0);
    measure(1'b0, "post_rst", 200, 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
